// File: rtl/dcache_axi_bridge_if.sv
// AXI4 master-side bus bundle used by the data-cache refill/writeback bridge.
// The master modport is the bridge; the slave modport is the memory side.
interface dcache_axi_bridge_if;
  // Read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // Write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: turns one data-cache line request (refill or writeback)
// into a single AXI4 INCR burst and pulses gnt_o for one cycle when the burst
// has fully completed. Every AXI output is decoded from registered state.
module dcache_axi_bridge #(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 req_addr_i,
  input  logic                        rd_req_i,
  input  logic                        wr_req_i,
  input  logic [LINE_WORDS-1:0][31:0] wr_data_i,
  output logic [LINE_WORDS-1:0][31:0] rd_data_o,
  output logic                        gnt_o,
  dcache_axi_bridge_if.master         axi
);

  localparam int unsigned      CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned      OFFSET_W  = CNT_W + 2;
  localparam logic [31:0]      LINE_MASK = ~((32'd1 << OFFSET_W) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP,
    DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [31:0]                 addr_q, addr_d;
  logic [LINE_WORDS-1:0][31:0] wbuf_q, wbuf_d;
  logic [LINE_WORDS-1:0][31:0] rd_data_q, rd_data_d;

  // Response codes are deliberately not acted on; keep them visibly consumed.
  logic unused_resp;
  assign unused_resp = ^{axi.rresp, axi.bresp};

  // State, beat counter, line address, write buffer and refill line registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wbuf_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wbuf_q    <= wbuf_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next-state and datapath updates; requests are only sampled in IDLE, so a
  // request still held during DONE cannot start a second burst.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wbuf_d    = wbuf_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (wr_req_i) begin
          addr_d  = req_addr_i & LINE_MASK;
          wbuf_d  = wr_data_i;
          state_d = WADDR;
        end else if (rd_req_i) begin
          addr_d  = req_addr_i & LINE_MASK;
          state_d = RADDR;
        end
      end
      RADDR: begin
        if (axi.arready) begin
          cnt_d   = '0;
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (axi.rvalid) begin
          rd_data_d[cnt_q] = axi.rdata;
          cnt_d            = cnt_q + 1'b1;
          if (axi.rlast) begin
            state_d = DONE;
          end
        end
      end
      WADDR: begin
        if (axi.awready) begin
          cnt_d   = '0;
          state_d = WDATA;
        end
      end
      WDATA: begin
        if (axi.wready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        if (axi.bvalid) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'(LINE_WORDS - 1);
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = (state_q == RADDR);
  assign axi.rready  = (state_q == RDATA);

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'(LINE_WORDS - 1);
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = (state_q == WADDR);

  assign axi.wdata   = wbuf_q[cnt_q];
  assign axi.wstrb   = 4'hF;
  assign axi.wlast   = (cnt_q == LAST_BEAT);
  assign axi.wvalid  = (state_q == WDATA);
  assign axi.bready  = (state_q == WRESP);

  assign gnt_o     = (state_q == DONE);
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Testbench for dcache_axi_bridge: a cache-side driver, a memory-backed AXI
// slave, and a scoreboard fed from a line-level memory model.
module tb_dcache_axi_bridge;

  typedef logic [7:0][31:0] line_t;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    line_t       line;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reqAddr;
  logic        rdReq;
  logic        wrReq;
  line_t       wrData;
  line_t       rdData;
  logic        gnt;

  dcache_axi_bridge_if axi ();

  dcache_axi_bridge #(.LINE_WORDS(8), .AXI_ID(4'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_addr_i (reqAddr),
    .rd_req_i   (rdReq),
    .wr_req_i   (wrReq),
    .wr_data_i  (wrData),
    .rd_data_o  (rdData),
    .gnt_o      (gnt),
    .axi        (axi)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t expQ[$];
  int   rlenQ[$];
  line_t modelRd = '0;
  logic [31:0] refMem [logic [31:0]];
  logic [31:0] slvMem [logic [31:0]];

  int cyc = 0;
  int burstStart = 0;
  int lastLat = 0;
  int arCnt = 0;
  int awCnt = 0;
  int rFireCnt = 0;

  int arDelay = 0;
  int awDelay = 0;
  int rGap = 0;
  int wMode = 0;
  bit bRand = 1'b0;

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return initWord(a);
  endfunction

  function automatic logic [31:0] slvRead(input logic [31:0] a);
    if (slvMem.exists(a)) return slvMem[a];
    return initWord(a);
  endfunction

  function automatic void pushWrite(input logic [31:0] addr, input line_t data);
    exp_t e;
    e.wr   = 1'b1;
    e.addr = addr & 32'hFFFF_FFE0;
    e.line = data;
    for (int i = 0; i < 8; i++) refMem[e.addr + 32'(4 * i)] = data[i];
    expQ.push_back(e);
  endfunction

  function automatic void pushRead(input logic [31:0] addr, input int nBeats);
    exp_t e;
    e.wr   = 1'b0;
    e.addr = addr & 32'hFFFF_FFE0;
    for (int i = 0; i < 8; i++)
      e.line[i] = (i < nBeats) ? refRead(e.addr + 32'(4 * i)) : modelRd[i];
    modelRd = e.line;
    expQ.push_back(e);
    rlenQ.push_back(nBeats);
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic finishRun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Raise a cache request, hold it until gnt, then drop it; both-high
  // requests expect the write first and keep rd held for a second grant.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] addr,
                               input line_t data, input int nBeats);
    int grants;
    int n;
    grants = (wr && rd) ? 2 : 1;
    if (wr) pushWrite(addr, data);
    if (rd) pushRead(addr, nBeats);
    reqAddr = addr;
    wrData  = data;
    wrReq   = wr;
    rdReq   = rd;
    for (int g = 0; g < grants; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!gnt && n < 400);
      if (!gnt) begin
        checkOutput("gnt_timeout", 256'(gnt), 256'(1));
        finishRun();
      end
      @(posedge clk);
      #1;
      wrReq = 1'b0;
      if (g == grants - 1) rdReq = 1'b0;
    end
  endtask

  // AXI slave backed by slvMem; readiness and gaps are set by the knobs.
  initial begin : slave
    int arWait, awWait, rGapCnt, rBeat, rN, wBeatS;
    bit rdActive, bPend, rstSeen;
    bit arFire, rFire, awFire, wFire, bFire, wLastCap;
    logic [31:0] rAddr, wAddr, arAddrCap, awAddrCap, wDataCap;
    arWait = 0; awWait = 0; rGapCnt = 0; rBeat = 0; rN = 8; wBeatS = 0;
    rdActive = 0; bPend = 0; rAddr = '0; wAddr = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    axi.rlast = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = '0;
    forever begin
      @(negedge clk);
      rstSeen   = rst;
      arFire    = axi.arvalid && axi.arready;
      rFire     = axi.rvalid && axi.rready;
      awFire    = axi.awvalid && axi.awready;
      wFire     = axi.wvalid && axi.wready;
      bFire     = axi.bvalid && axi.bready;
      arAddrCap = axi.araddr;
      awAddrCap = axi.awaddr;
      wDataCap  = axi.wdata;
      wLastCap  = axi.wlast;
      if (axi.arvalid && !axi.arready) arWait++;
      if (axi.awvalid && !axi.awready) awWait++;
      @(posedge clk);
      #1;
      if (rstSeen) begin
        arWait = 0; awWait = 0; rGapCnt = 0; rBeat = 0; wBeatS = 0;
        rdActive = 0; bPend = 0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        continue;
      end
      if (arFire) begin
        rdActive = 1; rAddr = arAddrCap; rBeat = 0; rGapCnt = 0; arWait = 0;
        rN = (rlenQ.size() > 0) ? rlenQ.pop_front() : 8;
      end
      if (rFire) begin
        rBeat++;
        if (rBeat == rN) rdActive = 0;
        rGapCnt = (rGap < 0) ? int'($urandom_range(0, 2)) : rGap;
      end else if (rGapCnt > 0 && !axi.rvalid) begin
        rGapCnt--;
      end
      axi.rvalid  = rdActive && (rGapCnt == 0);
      axi.rdata   = slvRead(rAddr + 32'(4 * rBeat));
      axi.rlast   = (rBeat == rN - 1);
      axi.rresp   = 2'($urandom_range(0, 3));
      axi.arready = (arDelay < 0) ? 1'($urandom_range(0, 1)) : (arWait >= arDelay);
      if (awFire) begin
        wAddr = awAddrCap; wBeatS = 0; awWait = 0;
      end
      axi.awready = (awDelay < 0) ? 1'($urandom_range(0, 1)) : (awWait >= awDelay);
      if (wFire) begin
        slvMem[wAddr + 32'(4 * wBeatS)] = wDataCap;
        wBeatS++;
        if (wLastCap) bPend = 1;
      end
      case (wMode)
        0:       axi.wready = 1'b1;
        1:       axi.wready = ~axi.wready;
        default: axi.wready = 1'($urandom_range(0, 1));
      endcase
      if (bFire) bPend = 0;
      if (bPend) axi.bvalid = axi.bvalid | (bRand ? 1'($urandom_range(0, 1)) : 1'b1);
      else       axi.bvalid = 1'b0;
      axi.bresp = 2'($urandom_range(0, 3));
    end
  end

  // Scoreboard monitor: checks every AXI handshake and every gnt against the
  // oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    bit   prevDone;
    int   wBeat;
    logic arvPrev, awvPrev;
    prevDone = 0; wBeat = 0; arvPrev = 0; awvPrev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prevDone = 0; wBeat = 0; arvPrev = 0; awvPrev = 0;
        continue;
      end
      if ((axi.arvalid && !arvPrev) || (axi.awvalid && !awvPrev)) burstStart = cyc;
      arvPrev = axi.arvalid;
      awvPrev = axi.awvalid;
      if (axi.arvalid && axi.arready) begin
        arCnt++;
        if (expQ.size() == 0 || expQ[0].wr) checkOutput("ar_unexpected", 256'(1), 256'(0));
        else begin
          checkOutput("araddr", 256'(axi.araddr), 256'(expQ[0].addr));
          checkOutput("ar_ctrl", 256'({axi.arid, axi.arlen, axi.arsize, axi.arburst}),
                      256'({4'd0, 8'd7, 3'd2, 2'd1}));
        end
      end
      if (axi.awvalid && axi.awready) begin
        awCnt++;
        wBeat = 0;
        if (expQ.size() == 0 || !expQ[0].wr) checkOutput("aw_unexpected", 256'(1), 256'(0));
        else begin
          checkOutput("awaddr", 256'(axi.awaddr), 256'(expQ[0].addr));
          checkOutput("aw_ctrl", 256'({axi.awid, axi.awlen, axi.awsize, axi.awburst}),
                      256'({4'd0, 8'd7, 3'd2, 2'd1}));
        end
      end
      if (axi.wvalid && axi.wready) begin
        if (expQ.size() == 0 || !expQ[0].wr || wBeat > 7)
          checkOutput("w_unexpected", 256'(1), 256'(0));
        else begin
          checkOutput("wdata", 256'(axi.wdata), 256'(expQ[0].line[wBeat]));
          checkOutput("wlast_wstrb", 256'({axi.wlast, axi.wstrb}), 256'({(wBeat == 7), 4'hF}));
        end
        wBeat++;
      end
      if (axi.rvalid && axi.rready) rFireCnt++;
      if (gnt) begin
        checkOutput("gnt_follows_last", 256'(prevDone), 256'(1));
        if (expQ.size() == 0) checkOutput("gnt_unexpected", 256'(1), 256'(0));
        else begin
          e = expQ.pop_front();
          lastLat = cyc - burstStart + 1;
          if (e.wr) checkOutput("w_beat_count", 256'(wBeat), 256'(8));
          else      checkOutput("rd_data", rdData, e.line);
        end
      end
      prevDone = (axi.rvalid && axi.rready && axi.rlast) || (axi.bvalid && axi.bready);
    end
  end

  // Hard time limit so the run always ends on its own.
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    finishRun();
  end

  // Directed scenarios followed by randomized traffic.
  initial begin : stimulus
    int    kind, nb, base, n, activity, awBefore, arBefore;
    logic [31:0] a;
    line_t d;
    rst = 1'b1; rdReq = 1'b0; wrReq = 1'b0; reqAddr = '0; wrData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valids",
                256'({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, gnt}), 256'(0));
    checkOutput("reset_rd_data", rdData, 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] zero-wait refill from 0x1FC0_0024");
    for (int i = 0; i < 8; i++) begin
      refMem[32'h1FC0_0020 + 32'(4 * i)] = 32'h100 + 32'(i);
      slvMem[32'h1FC0_0020 + 32'(4 * i)] = 32'h100 + 32'(i);
    end
    applyStimulus(1'b0, 1'b1, 32'h1FC0_0024, '0, 8);
    checkOutput("read_latency", 256'(lastLat), 256'(10));

    $display("[TB] writeback to 0x1040 with slow AW and toggling wready");
    awDelay = 3; wMode = 1;
    for (int i = 0; i < 8; i++) d[i] = 32'hA0 + 32'(i);
    applyStimulus(1'b1, 1'b0, 32'h0000_1040, d, 8);

    $display("[TB] back-to-back writeback then refill");
    awDelay = 0; wMode = 0;
    awBefore = awCnt; arBefore = arCnt;
    for (int i = 0; i < 8; i++) d[i] = $urandom;
    applyStimulus(1'b1, 1'b0, 32'h0000_2000, d, 8);
    checkOutput("write_latency", 256'(lastLat), 256'(11));
    applyStimulus(1'b0, 1'b1, 32'h0000_3000, '0, 8);
    checkOutput("aw_burst_count", 256'(awCnt - awBefore), 256'(1));
    checkOutput("ar_burst_count", 256'(arCnt - arBefore), 256'(1));

    $display("[TB] simultaneous rd_req and wr_req");
    for (int i = 0; i < 8; i++) d[i] = $urandom;
    applyStimulus(1'b1, 1'b1, 32'h0000_5060, d, 8);

    $display("[TB] refill with rvalid gaps and early rlast");
    rGap = 2;
    applyStimulus(1'b0, 1'b1, 32'h0000_4000, '0, 6);
    rGap = 0;

    $display("[TB] reset in the middle of a refill");
    base = rFireCnt;
    pushRead(32'h0000_6000, 8);
    reqAddr = 32'h0000_6000;
    rdReq = 1'b1;
    n = 0;
    while (rFireCnt - base < 4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("rst_reached_beat4", 256'(rFireCnt - base), 256'(4));
    rst = 1'b1;
    rdReq = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    rlenQ.delete();
    modelRd = '0;
    @(negedge clk);
    checkOutput("rst_rready_gnt", 256'({axi.rready, gnt}), 256'(0));
    checkOutput("rst_other_valids",
                256'({axi.arvalid, axi.awvalid, axi.wvalid, axi.bready}), 256'(0));
    checkOutput("rst_mid_rd_data", rdData, 256'(0));
    activity = 0;
    repeat (20) begin
      @(negedge clk);
      if (axi.arvalid || axi.awvalid || axi.wvalid || axi.rready || axi.bready || gnt)
        activity++;
    end
    checkOutput("idle_after_rst", 256'(activity), 256'(0));
    @(posedge clk);
    #1;

    $display("[TB] randomized traffic");
    arDelay = -1; awDelay = -1; rGap = -1; wMode = 2; bRand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      for (int i = 0; i < 8; i++) d[i] = $urandom;
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 8;
      if (kind < 4)       applyStimulus(1'b1, 1'b0, a, d, nb);
      else if (kind < 9)  applyStimulus(1'b0, 1'b1, a, d, nb);
      else                applyStimulus(1'b1, 1'b1, a, d, nb);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_drained", 256'(expQ.size()), 256'(0));
    finishRun();
  end

endmodule

// File: doc/dcache_axi_bridge.md
Name: dcache_axi_bridge

Overview:
- Responder to the data cache's line-refill/writeback request interface; initiator on the AXI4 master bus toward memory.
- Converts one cache request (8-word, 32-byte aligned line) into one AXI4 INCR burst: read (AR+R) or write (AW+W+B).
- Pulses gnt for one cycle on completion. The cache holds its request until gnt, then advances.

Parameters:
- LINE_WORDS, 8, words per line; fixed burst length (arlen/awlen = LINE_WORDS-1).
- AXI_ID, 4'd0, constant value driven on arid/awid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_addr  in  32  line address from cache; bits [4:0] ignored, forced to 0 on the bus
- rd_req  in  1  line refill request, level, held until gnt
- wr_req  in  1  line writeback request, level, held until gnt
- wr_data  in  32x8  writeback line, word i at byte offset 4i
- rd_data  out  32x8  refill line, registered
- gnt  out  1  one-cycle completion pulse
- arid/awid  out  4  AXI_ID
- araddr/awaddr  out  32  burst start address
- arlen/awlen  out  8  7
- arsize/awsize  out  3  3'b010
- arburst/awburst  out  2  2'b01 (INCR)
- arvalid, arready  out/in  1  AR handshake
- rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1
- awvalid, awready  out/in  1  AW handshake
- wdata  out  32; wstrb  out  4 (always 4'hF); wlast  out  1; wvalid  out  1; wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Reset: state IDLE; arvalid, awvalid, wvalid, rready, bready, gnt = 0; beat counter = 0; rd_data all zero. Reset mid-burst drops all valids the next edge; no completion is sent.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
- IDLE: if wr_req, latch {req_addr[31:5],5'b0} into addr register and latch all 8 wr_data words into a write buffer -> WADDR. Else if rd_req, latch addr -> RADDR. wr_req wins if both are high. Requests are ignored in DONE and in all busy states.
- RADDR: arvalid=1, araddr=addr. Leave on arvalid&arready -> RDATA, counter=0.
- RDATA: rready=1. On each rvalid, rd_data[counter] <= rdata and counter++ (3-bit wrap). On rvalid&rlast -> DONE. rresp is ignored. If rlast arrives before beat 7, remaining words are left unchanged.
- WADDR: awvalid=1, awaddr=addr. On awready -> WDATA, counter=0. AW completes before W starts; no overlap.
- WDATA: wvalid=1, wdata=buffer[counter], wlast=(counter==7). On wready, counter++. On wready&wlast -> WRESP.
- WRESP: bready=1. On bvalid -> DONE. bresp is ignored.
- DONE: gnt=1 for exactly one cycle -> IDLE. The earliest new acceptance is the cycle after DONE; this guarantees a held request is not re-issued.
- rd_data holds its value from DONE until the next read's first beat. The cache writes it one cycle after gnt.
- All AXI outputs are registered or decoded from state only, with no combinational path from AXI inputs. valid stays high until its ready arrives; payload is stable while valid.
- Latency with zero-wait slave: read = 1 (AR) + 8 (R) + 1 (DONE) cycles after acceptance. Write = 1 + 8 + 1 (B) + 1.

Test Plan:
- rd_req, req_addr=0x1FC0_0024, slave ready always, rdata=0x100+i -> araddr=0x1FC0_0020, arlen=7, arsize=2, arburst=1. gnt pulses once 10 cycles after arvalid rises. rd_data[i]=0x100+i.
- wr_req, req_addr=0x0000_1040, wr_data[i]=0xA0+i, awready delayed 3 cycles, wready toggling 1/0 -> awaddr=0x1040. wdata sequence 0xA0..0xA7 in order, with no beat lost or duplicated. wlast only on the 8th beat, wstrb=F. gnt occurs one cycle after bvalid.
- Cache-style back-to-back: wr_req to 0x2000, then rd_req to 0x3000 raised the cycle after gnt -> exactly one AW burst, then one AR burst. No second AW.
- rd_req and wr_req both high -> write burst performed first. arvalid stays 0 until the write's gnt.
- rst asserted during RDATA beat 4 -> next edge: rready=0, gnt=0, state IDLE. With rd_req low after reset, no further AXI activity.
- rvalid stalls (gaps of 2 cycles between beats) and early rlast on beat 5 -> captured words are correct, words 6..7 keep prior values, gnt follows rlast by one cycle.
